gray_frame_sequencer: RTL

//  Frame-level controller for the RGB->grayscale stage of the Sobel pipeline.
//  - Arms on software start and syncs to camera VSYNC.
//  - Gates the camera pixel-valid into the converter's enable input.
//  - Tracks column/row position.
//  - Emits SOL/EOL/SOF/EOF markers aligned to the converter's 1-cycle output.
//  - Reports frame completion and framing errors to the downstream Sobel window buffer.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/gray_frame_sequencer_if.sv | 41 ++++
 rtl/gray_frame_sequencer_pixel_pos_counter.sv | 56 +++++
 rtl/gray_frame_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel pipeline front end.
// Contents:
//   IMG_W_DEF / IMG_H_DEF / CNT_W_DEF  default frame geometry and counter width
//   gseq_state_t                       frame sequencer state
//   pix_pos_t                          {row, col} pixel position for downstream stages
package sobel_pkg;

  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    ACTIVE = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } gseq_state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] row;
    logic [CNT_W_DEF-1:0] col;
  } pix_pos_t;

endpackage

// File: rtl/gray_frame_sequencer_if.sv
// Control/status bundle between the camera/converter side and the frame sequencer.
// master: drives start/abort, camera VSYNC/valid and converter done; observes the rest.
// slave : the sequencer itself.
//   start_i, abort_i, cam_vsync_i, cam_valid_i, gs_done_i   -> sequencer
//   gs_en_o, col_o, row_o, sol_o, eol_o, sof_o, eof_o,
//   busy_o, frame_done_o, err_o                            <- sequencer
interface gray_frame_sequencer_if
  import sobel_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             start_i;
  logic             abort_i;
  logic             cam_vsync_i;
  logic             cam_valid_i;
  logic             gs_done_i;
  logic             gs_en_o;
  logic [CNT_W-1:0] col_o;
  logic [CNT_W-1:0] row_o;
  logic             sol_o;
  logic             eol_o;
  logic             sof_o;
  logic             eof_o;
  logic             busy_o;
  logic             frame_done_o;
  logic             err_o;

  modport master (
    output start_i, abort_i, cam_vsync_i, cam_valid_i, gs_done_i,
    input  gs_en_o, col_o, row_o, sol_o, eol_o, sof_o, eof_o,
           busy_o, frame_done_o, err_o
  );

  modport slave (
    input  start_i, abort_i, cam_vsync_i, cam_valid_i, gs_done_i,
    output gs_en_o, col_o, row_o, sol_o, eol_o, sof_o, eof_o,
           busy_o, frame_done_o, err_o
  );

endinterface

// File: rtl/gray_frame_sequencer_pixel_pos_counter.sv
// pixel_pos_counter: raster col/row counter with wrap and position flags.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   clr              force position to (0,0)
//   adv              advance one pixel (col wraps at IMG_W-1 and bumps row)
//   col, row         current position (registered)
//   first_col_c      col == 0
//   first_row_c      row == 0
//   last_col_c       col == IMG_W-1
//   last_pix_c       (IMG_W-1, IMG_H-1)
module pixel_pos_counter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             first_col_c,
  output logic             first_row_c,
  output logic             last_col_c,
  output logic             last_pix_c
);

  logic last_row_c;

  assign first_col_c = (col == '0);
  assign first_row_c = (row == '0);
  assign last_col_c  = (col == CNT_W'(IMG_W - 1));
  assign last_row_c  = (row == CNT_W'(IMG_H - 1));
  assign last_pix_c  = last_col_c & last_row_c;

  // Raster advance; the last pixel wraps the whole frame back to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (last_col_c) begin
        col <= '0;
        row <= last_row_c ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gray_frame_sequencer.sv
// gray_frame_sequencer: frame-level controller for the RGB->grayscale stage.
// Arms on start_i, syncs to a VSYNC rising edge, gates camera valid into the
// converter enable, tracks position and emits SOL/EOL/SOF/EOF aligned to the
// converter's one-cycle-late done_o.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   bus (slave)   start_i, abort_i, cam_vsync_i, cam_valid_i, gs_done_i in;
//                 gs_en_o (combinational), col_o/row_o, sol/eol/sof/eof_o,
//                 busy_o, frame_done_o, err_o (sticky) out
// Build option:
//   GRAY_FRAME_SEQ_CONTINUOUS_EN  defined: DONE re-arms for the next VSYNC
//                                 undefined: DONE returns to IDLE
module gray_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gray_frame_sequencer_if.slave bus
);

  gseq_state_t      state_q, next_state;
  logic             vsync_q;
  logic             vsync_rise;
  logic             gs_en_c;
  logic             cnt_clr, cnt_adv;
  logic             err_set, err_clr;

  logic [CNT_W-1:0] cnt_col, cnt_row;
  logic             first_col, first_row, last_col, last_pix;

  logic             issued_q;
  logic [CNT_W-1:0] col_q, row_q;
  logic             sol_q, eol_q, sof_q, eof_q;
  logic             busy_q, frame_done_q, err_q;

  assign vsync_rise = bus.cam_vsync_i & ~vsync_q;

  pixel_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W)
  ) u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (cnt_clr),
    .adv         (cnt_adv),
    .col         (cnt_col),
    .row         (cnt_row),
    .first_col_c (first_col),
    .first_row_c (first_row),
    .last_col_c  (last_col),
    .last_pix_c  (last_pix)
  );

  // State register and VSYNC edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
    end else begin
      state_q <= next_state;
      vsync_q <= bus.cam_vsync_i;
    end
  end

  // Next state, converter enable, counter control and error detection.
  always_comb begin
    next_state = state_q;
    gs_en_c    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    err_clr    = 1'b0;
    // A converter result with nothing issued last cycle is a framing error.
    err_set    = bus.gs_done_i & ~issued_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          next_state = ARMED;
          err_clr    = 1'b1;
        end
      end
      ARMED: begin
        if (vsync_rise) begin
          next_state = ACTIVE;
          cnt_clr    = 1'b1;
        end
      end
      ACTIVE: begin
        // A new VSYNC mid-frame restarts capture; the coincident pixel is dropped.
        if (vsync_rise) begin
          cnt_clr = 1'b1;
          err_set = 1'b1;
        end else if (bus.cam_valid_i) begin
          gs_en_c = 1'b1;
          cnt_adv = 1'b1;
          if (last_pix) next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.cam_valid_i) err_set = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        if (bus.cam_valid_i) err_set = 1'b1;
`ifdef GRAY_FRAME_SEQ_CONTINUOUS_EN
        next_state = ARMED;
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase

    // Abort overrides every transition and suppresses the pixel this cycle.
    if (bus.abort_i) begin
      next_state = IDLE;
      gs_en_c    = 1'b0;
      cnt_adv    = 1'b0;
      err_clr    = 1'b0;
    end
  end

  // Position/markers of the issued pixel, lined up with the converter output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q     <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      sol_q        <= 1'b0;
      eol_q        <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      issued_q     <= gs_en_c;
      col_q        <= gs_en_c ? cnt_col : '0;
      row_q        <= gs_en_c ? cnt_row : '0;
      sol_q        <= gs_en_c & first_col;
      eol_q        <= gs_en_c & last_col;
      sof_q        <= gs_en_c & first_col & first_row;
      eof_q        <= gs_en_c & last_pix;
      busy_q       <= (next_state != IDLE);
      frame_done_q <= (next_state == DONE);
      err_q        <= (err_q & ~err_clr) | err_set;
    end
  end

  assign bus.gs_en_o      = gs_en_c;
  // Position data is only meaningful while the converter presents a result.
  assign bus.col_o        = bus.gs_done_i ? col_q : '0;
  assign bus.row_o        = bus.gs_done_i ? row_q : '0;
  assign bus.sol_o        = sol_q & bus.gs_done_i;
  assign bus.eol_o        = eol_q & bus.gs_done_i;
  assign bus.sof_o        = sof_q & bus.gs_done_i;
  assign bus.eof_o        = eof_q & bus.gs_done_i;
  assign bus.busy_o       = busy_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.err_o        = err_q;

endmodule
